// File: rtl/alu_pkg.sv
// alu_pkg: Funct codes, ALUOp encodings and FSM state type for alu_mdu_unit
package alu_pkg;
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_e;
endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: one-bit-per-cycle shift-add multiplier / restoring divider on magnitudes
// Ports: clk, reset (async, active-high); load_i latches operands and op type;
// step_i advances one iteration; last_o flags the final iteration;
// hi_o/lo_o present the sign-corrected product or remainder/quotient.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2(WIDTH);
  logic [CW-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, m_q, hi_d, lo_d, mag_a, mag_b;
  logic div_q, neg_lo_q, neg_hi_q, dz_q, sa, sb;
  logic [WIDTH:0] sum, shifted, diff;
  logic [2*WIDTH-1:0] prod;
  assign sa = signed_i & a_i[WIDTH-1];
  assign sb = signed_i & b_i[WIDTH-1];
  assign mag_a = sa ? -a_i : a_i;
  assign mag_b = sb ? -b_i : b_i;
  assign last_o = cnt_q == CW'(WIDTH - 1);
  // Multiply: {hi,lo} shifts right, lo starts as multiplier, m is multiplicand.
  // Divide: {hi,lo} shifts left, hi is partial remainder, lo collects quotient bits.
  always_comb begin
    sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff = shifted - {1'b0, m_q};
    hi_d = div_q ? (diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
    lo_d = div_q ? {lo_q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], lo_q[WIDTH-1:1]};
    prod = neg_lo_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  end
  // A zero divisor yields an all-ones quotient and the dividend as remainder.
  assign hi_o = div_q ? (neg_hi_q ? -hi_q : hi_q) : prod[2*WIDTH-1:WIDTH];
  assign lo_o = div_q ? (dz_q ? '1 : neg_lo_q ? -lo_q : lo_q) : prod[WIDTH-1:0];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      m_q <= '0;
      div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q <= 1'b0;
    end else if (load_i) begin
      cnt_q <= '0;
      div_q <= div_i;
      neg_lo_q <= sa ^ sb;
      neg_hi_q <= sa;
      dz_q <= b_i == '0;
      hi_q <= '0;
      lo_q <= div_i ? mag_a : mag_b;
      m_q <= div_i ? mag_b : mag_a;
    end else if (step_i) begin
      cnt_q <= cnt_q + CW'(1);
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
endmodule

// File: rtl/alu_mdu_unit.sv
// alu_mdu_unit: single-cycle ALU plus iterative multiply/divide with HI/LO registers
// Ports: clk, reset (async, active-high); start/ALUOp/Funct/SrcA/SrcB request;
// Result/Zero registered ALU output; done/illegal one-cycle pulses; busy during mul/div.
module alu_mdu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             done,
  output logic             busy,
  output logic             illegal
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] result_q, hi_q, lo_q, res, mdu_hi, mdu_lo;
  logic zero_q, done_q, illegal_q, accept, mc, ill, last;
  assign busy = state_q != S_IDLE;
  assign accept = start & ~busy;
  assign Result = result_q;
  assign Zero = zero_q;
  assign done = done_q;
  assign illegal = illegal_q;
  always_comb begin
    res = '0;
    mc = 1'b0;
    ill = 1'b0;
    if (ALUOp == ALUOP_ADD) res = SrcA + SrcB;
    else if (ALUOp == ALUOP_SUB) res = SrcA - SrcB;
    else
      case (Funct)
        F_ADD:  res = SrcA + SrcB;
        F_SUB:  res = SrcA - SrcB;
        F_AND:  res = SrcA & SrcB;
        F_OR:   res = SrcA | SrcB;
        F_XOR:  res = SrcA ^ SrcB;
        F_NOR:  res = ~(SrcA | SrcB);
        F_SLT:  res = WIDTH'($signed(SrcA) < $signed(SrcB));
        F_SLTU: res = WIDTH'(SrcA < SrcB);
        F_MFHI: res = hi_q;
        F_MFLO: res = lo_q;
        F_MULT, F_MULTU, F_DIV, F_DIVU: mc = 1'b1;
        default: ill = 1'b1;
      endcase
  end
  assign state_d = state_q == S_IDLE ? ((accept & mc) ? S_CALC : S_IDLE) :
                   state_q == S_CALC ? (last ? S_FINISH : S_CALC) : S_IDLE;
  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk      (clk),
    .reset    (reset),
    .load_i   (accept & mc),
    .step_i   (state_q == S_CALC),
    .div_i    (Funct[1]),
    .signed_i (~Funct[0]),
    .a_i      (SrcA),
    .b_i      (SrcB),
    .last_o   (last),
    .hi_o     (mdu_hi),
    .lo_o     (mdu_lo)
  );
  // Illegal requests fall through with res = 0, so they clear Result and set Zero.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      result_q <= '0;
      zero_q <= 1'b1;
      done_q <= 1'b0;
      illegal_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      done_q <= (accept & ~mc) | ((state_q == S_CALC) & last);
      illegal_q <= accept & ill;
      if (accept & ~mc) begin
        result_q <= res;
        zero_q <= res == '0;
      end
      if (state_q == S_FINISH) begin
        hi_q <= mdu_hi;
        lo_q <= mdu_lo;
      end
    end
endmodule

// File: tb/tb_alu_mdu_unit.sv
// tb_alu_mdu_unit: randomized and directed checks of alu_mdu_unit against a behavioural model
module tb_alu_mdu_unit;
  localparam int W = 32;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [1:0] ALUOp = '0;
  logic [5:0] Funct = '0;
  logic [31:0] SrcA = '0, SrcB = '0;
  logic [31:0] Result;
  logic Zero, done, busy, illegal;
  int n_chk = 0, n_fail = 0;
  logic [31:0] m_res = '0, m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic m_zero = 1'b1, m_done = 1'b0, m_ill = 1'b0;
  int m_left = 0;
  logic [5:0] fl [14] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010,
                          6'b101011, 6'b010000, 6'b010010, 6'b011000, 6'b011001, 6'b011010, 6'b011011};

  alu_mdu_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUOp(ALUOp), .Funct(Funct), .SrcA(SrcA), .SrcB(SrcB),
    .Result(Result), .Zero(Zero), .done(done), .busy(busy), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic model_accept();
    logic [31:0] r;
    logic il;
    longint x;
    logic [63:0] u;
    int sa, sb;
    r = '0;
    il = 1'b0;
    sa = $signed(SrcA);
    sb = $signed(SrcB);
    if (ALUOp == 2'b00) r = SrcA + SrcB;
    else if (ALUOp == 2'b01) r = SrcA - SrcB;
    else
      case (Funct)
        6'h20: r = SrcA + SrcB;
        6'h22: r = SrcA - SrcB;
        6'h24: r = SrcA & SrcB;
        6'h25: r = SrcA | SrcB;
        6'h26: r = SrcA ^ SrcB;
        6'h27: r = ~(SrcA | SrcB);
        6'h2a: r = (sa < sb) ? 32'd1 : 32'd0;
        6'h2b: r = (SrcA < SrcB) ? 32'd1 : 32'd0;
        6'h10: r = m_hi;
        6'h12: r = m_lo;
        6'h18: begin x = longint'(sa) * longint'(sb); {p_hi, p_lo} = x; m_left = W + 1; return; end
        6'h19: begin u = 64'(SrcA) * 64'(SrcB); {p_hi, p_lo} = u; m_left = W + 1; return; end
        6'h1a: begin
          if (SrcB == 0) begin p_lo = '1; p_hi = SrcA; end
          else if (SrcA == 32'h80000000 && SrcB == 32'hFFFFFFFF) begin p_lo = SrcA; p_hi = 0; end
          else begin p_lo = 32'(sa / sb); p_hi = 32'(sa % sb); end
          m_left = W + 1;
          return;
        end
        6'h1b: begin
          if (SrcB == 0) begin p_lo = '1; p_hi = SrcA; end
          else begin p_lo = SrcA / SrcB; p_hi = SrcA % SrcB; end
          m_left = W + 1;
          return;
        end
        default: il = 1'b1;
      endcase
    m_done = 1'b1;
    m_ill = il;
    m_res = il ? 32'd0 : r;
    m_zero = m_res == 0;
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_res = 0; m_zero = 1; m_done = 0; m_ill = 0; m_left = 0; m_hi = 0; m_lo = 0;
    end else begin
      m_done = 0;
      m_ill = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
      end else if (start) model_accept();
      if (m_left == 1) m_done = 1;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("Result", Result, m_res);
    chk("Zero", Zero, m_zero);
    chk("done", done, m_done);
    chk("busy", busy, m_left > 0);
    chk("illegal", illegal, m_ill);
  end

  task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    ALUOp = op; Funct = f; SrcA = a; SrcB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy && c < 60) begin
      SrcA = $urandom; SrcB = $urandom; c++;
      @(negedge clk);
    end
    chk("idle_timeout", busy, 0);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int c, dc, bad;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_result", Result, 0);
    chk("rst_zero", Zero, 1);
    chk("rst_busy", busy, 0);
    #2 reset = 1'b0;
    issue(2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1);
    chk("slt_res", Result, 1);
    chk("slt_done", done, 1);
    issue(2'b10, 6'b101011, 32'hFFFFFFFF, 32'd1);
    chk("sltu_res", Result, 0);
    chk("sltu_zero", Zero, 1);
    issue(2'b10, 6'b011000, 32'hFFFFFFFD, 32'd7);
    c = 0; dc = -1;
    while (busy && c < 100) begin
      c++;
      if (done) dc = c;
      @(negedge clk);
    end
    chk("mult_busy_cycles", c, 33);
    chk("mult_done_at", dc, 33);
    issue(2'b10, 6'b010000, 0, 0);
    chk("mult_hi", Result, 32'hFFFFFFFF);
    issue(2'b10, 6'b010010, 0, 0);
    chk("mult_lo", Result, 32'hFFFFFFEB);
    issue(2'b10, 6'b011010, 32'hFFFFFFF9, 32'd2);
    wait_idle();
    issue(2'b10, 6'b010010, 0, 0);
    chk("div_lo", Result, 32'hFFFFFFFD);
    issue(2'b10, 6'b010000, 0, 0);
    chk("div_hi", Result, 32'hFFFFFFFF);
    issue(2'b10, 6'b011010, 32'h80000000, 32'hFFFFFFFF);
    wait_idle();
    issue(2'b10, 6'b010010, 0, 0);
    chk("divmin_lo", Result, 32'h80000000);
    issue(2'b10, 6'b010000, 0, 0);
    chk("divmin_hi", Result, 0);
    issue(2'b10, 6'b011011, 32'd5, 32'd0);
    wait_idle();
    issue(2'b10, 6'b010010, 0, 0);
    chk("divu0_lo", Result, 32'hFFFFFFFF);
    issue(2'b10, 6'b010000, 0, 0);
    chk("divu0_hi", Result, 5);
    issue(2'b00, 6'b0, 32'd1, 32'd1);
    chk("add_res", Result, 2);
    issue(2'b10, 6'b011001, 32'hDEADBEEF, 32'h12345678);
    ALUOp = 2'b00; SrcA = 32'd100; SrcB = 32'd23; start = 1'b1;
    c = 0; bad = 0;
    while (busy && c < 100) begin
      if (Result !== 32'd2) bad++;
      c++;
      @(negedge clk);
    end
    chk("busy_hold_changes", bad, 0);
    @(negedge clk);
    start = 1'b0;
    chk("late_add_res", Result, 123);
    chk("late_add_done", done, 1);
    issue(2'b10, 6'b011001, 32'h12345678, 32'h9ABCDEF0);
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_result", Result, 0);
    chk("abort_zero", Zero, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    issue(2'b10, 6'b010000, 0, 0);
    chk("abort_hi", Result, 0);
    chk("abort_accept", done, 1);
    issue(2'b10, 6'b010010, 0, 0);
    chk("abort_lo", Result, 0);
    issue(2'b00, 6'b0, 32'd5, 32'd6);
    chk("pre_ill_res", Result, 11);
    issue(2'b10, 6'b000001, 32'd7, 32'd9);
    chk("ill_pulse", illegal, 1);
    chk("ill_done", done, 1);
    chk("ill_res", Result, 0);
    @(negedge clk);
    chk("ill_once", illegal, 0);
    for (int i = 0; i < 300; i++) begin
      logic [5:0] f;
      f = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fl[$urandom_range(0, 13)];
      issue(2'($urandom_range(0, 3)), f, rnd_op(), rnd_op());
      wait_idle();
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
